// File: rtl/mul_seq.sv
// Iterative signed fixed-point multiplier: radix-2 shift-add on operand magnitudes,
// early exit when the remaining multiplier bits are zero, optional Q rescale and clamp.
module mul_seq #(
  parameter int DWIDTH   = 32,
  parameter int QBITS    = 0,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DWIDTH-1:0] multiplicand,
  input  logic [DWIDTH-1:0] multiplier,
  output logic [DWIDTH-1:0] product,
  output logic              overflow,
  output logic              done,
  output logic              busy
);

  localparam int W2 = 2 * DWIDTH;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [W2-1:0] POS_LIM = {{(DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic [W2-1:0] NEG_LIM = {{DWIDTH{1'b0}}, 1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [DWIDTH-1:0] MOST_POS = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

  logic [0:0]        state_q, state_d;
  logic [W2-1:0]     a_sh_q, a_sh_d;
  logic [DWIDTH-1:0] b_sh_q, b_sh_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic              sgn_q, sgn_d;
  logic [DWIDTH-1:0] product_q, product_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Unsigned reading of the negated most-negative value is exactly 2^(DWIDTH-1).
  logic [DWIDTH-1:0] a_mag, b_mag;
  assign a_mag = multiplicand[DWIDTH-1] ? -multiplicand : multiplicand;
  assign b_mag = multiplier[DWIDTH-1]   ? -multiplier   : multiplier;

  logic [W2-1:0]     res_m;
  logic [W2-1:0]     res_lim;
  logic [DWIDTH-1:0] res_m_lo;
  logic              res_ovf;
  logic [DWIDTH-1:0] res_prod;

  always_comb begin
    res_m    = acc_q >> QBITS;
    res_lim  = sgn_q ? NEG_LIM : POS_LIM;
    res_m_lo = res_m[DWIDTH-1:0];
    res_ovf  = (res_m > res_lim);
    if (SATURATE && res_ovf) begin
      res_prod = sgn_q ? MOST_NEG : MOST_POS;
    end else begin
      res_prod = sgn_q ? -res_m_lo : res_m_lo;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    acc_d      = acc_q;
    sgn_d      = sgn_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    done_d     = done_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = {{DWIDTH{1'b0}}, a_mag};
          b_sh_d  = b_mag;
          sgn_d   = multiplicand[DWIDTH-1] ^ multiplier[DWIDTH-1];
          acc_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        if (b_sh_q == '0) begin
          product_d  = res_prod;
          overflow_d = res_ovf;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          if (b_sh_q[0]) begin
            acc_d = acc_q + a_sh_q;
          end
          a_sh_d = a_sh_q << 1;
          b_sh_d = b_sh_q >> 1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      acc_q      <= '0;
      sgn_q      <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      acc_q      <= acc_d;
      sgn_q      <= sgn_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign product  = product_q;
  assign overflow = overflow_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: three parameterisations driven in lockstep, checked every cycle
// against an arithmetic reference model, plus literal expectations for known cases.
module tb_mul_seq;

  localparam int QV [3] = '{16, 16, 0};
  localparam bit SV [3] = '{1'b1, 1'b0, 1'b1};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_in  = '0;
  logic [31:0] b_in  = '0;

  logic [31:0] prod_s16, prod_w16, prod_s0;
  logic        ovf_s16, ovf_w16, ovf_s0;
  logic        done_s16, done_w16, done_s0;
  logic        busy_s16, busy_w16, busy_s0;

  mul_seq #(.DWIDTH(32), .QBITS(16), .SATURATE(1'b1)) dut_s16 (
    .clock(clock), .reset(reset), .start(start), .multiplicand(a_in), .multiplier(b_in),
    .product(prod_s16), .overflow(ovf_s16), .done(done_s16), .busy(busy_s16));
  mul_seq #(.DWIDTH(32), .QBITS(16), .SATURATE(1'b0)) dut_w16 (
    .clock(clock), .reset(reset), .start(start), .multiplicand(a_in), .multiplier(b_in),
    .product(prod_w16), .overflow(ovf_w16), .done(done_w16), .busy(busy_w16));
  mul_seq #(.DWIDTH(32), .QBITS(0), .SATURATE(1'b1)) dut_s0 (
    .clock(clock), .reset(reset), .start(start), .multiplicand(a_in), .multiplier(b_in),
    .product(prod_s0), .overflow(ovf_s0), .done(done_s0), .busy(busy_s0));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {overflow, product} from signed arithmetic on 64-bit magnitudes.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input int q, input bit sat);
    longint sa, sb;
    logic [63:0] ma, mb, m, lim, neg;
    logic s, ov;
    logic [31:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ma = (sa < 0) ? 64'(-sa) : 64'(sa);
    mb = (sb < 0) ? 64'(-sb) : 64'(sb);
    m  = (ma * mb) >> q;
    s  = a[31] ^ b[31];
    lim = s ? 64'h8000_0000 : 64'h7FFF_FFFF;
    ov = (m > lim);
    neg = -m;
    if (sat && ov) p = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else           p = s ? neg[31:0] : m[31:0];
    return {ov, p};
  endfunction

  // Shift-add cycles: number of significant bits in |B|.
  function automatic int lat_k(input logic [31:0] b);
    longint sb, mb;
    sb = longint'($signed(b));
    mb = (sb < 0) ? -sb : sb;
    return (mb == 0) ? 0 : $clog2(mb + 1);
  endfunction

  // Cycle-level model of the handshake: countdown of k cycles, then completion.
  logic        m_busy, m_done;
  int          m_cnt;
  logic [31:0] m_a, m_b;
  logic [31:0] m_prod [3];
  logic        m_ovf  [3];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      for (int i = 0; i < 3; i++) begin
        m_prod[i] <= '0;
        m_ovf[i]  <= 1'b0;
      end
    end else if (!m_busy) begin
      if (start) begin
        m_a    <= a_in;
        m_b    <= b_in;
        m_cnt  <= lat_k(b_in);
        m_busy <= 1'b1;
        m_done <= 1'b0;
      end
    end else if (m_cnt == 0) begin
      for (int i = 0; i < 3; i++) begin
        {m_ovf[i], m_prod[i]} <= ref_mul(m_a, m_b, QV[i], SV[i]);
      end
      m_done <= 1'b1;
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  logic [31:0] d_prod [3];
  logic        d_ovf  [3];
  logic        d_done [3];
  logic        d_busy [3];
  assign d_prod[0] = prod_s16; assign d_prod[1] = prod_w16; assign d_prod[2] = prod_s0;
  assign d_ovf[0]  = ovf_s16;  assign d_ovf[1]  = ovf_w16;  assign d_ovf[2]  = ovf_s0;
  assign d_done[0] = done_s16; assign d_done[1] = done_w16; assign d_done[2] = done_s0;
  assign d_busy[0] = busy_s16; assign d_busy[1] = busy_w16; assign d_busy[2] = busy_s0;

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy[%0d]", i), 32'(d_busy[i]), 32'(m_busy));
      chk($sformatf("done[%0d]", i), 32'(d_done[i]), 32'(m_done));
      chk($sformatf("product[%0d]", i), d_prod[i], m_prod[i]);
      chk($sformatf("overflow[%0d]", i), 32'(d_ovf[i]), 32'(m_ovf[i]));
    end
  end

  // One transaction; optionally re-pulses start with junk operands at cycle 'poke'.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int poke,
                        output int lat, output int busy_cnt);
    @(negedge clock);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    chk("done_drop", 32'(done_s16), 32'd0);
    busy_cnt = busy_s16 ? 1 : 0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (done_s16) break;
      if (busy_s16) busy_cnt++;
      start = (lat == poke);
    end
    start = 1'b0;
    chk("done_timeout", 32'(done_s16), 32'd1);
    $display("op a=%h b=%h lat=%0d prod16=%h ovf16=%0d prod0=%h", a, b, lat, prod_s16, ovf_s16, prod_s0);
  endtask

  int lat, bcnt;
  logic [32:0] r;
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_product", prod_s16, 32'h0);
    chk("rst_done", 32'(done_s16), 32'd0);
    chk("rst_busy", 32'(busy_s16), 32'd0);
    reset = 1'b0;

    r = ref_mul(32'h0003_0000, 32'hFFFD_8000, 16, 1'b1);
    chk("model_t1_prod", r[31:0], 32'hFFF8_8000);
    chk("model_t1_lat", 32'(lat_k(32'hFFFD_8000)), 32'd18);
    r = ref_mul(32'h7FFF_0000, 32'h0002_0000, 16, 1'b0);
    chk("model_wrap_prod", r[31:0], 32'hFFFE_0000);
    chk("model_wrap_ovf", 32'(r[32]), 32'd1);

    run_op(32'h0003_0000, 32'hFFFD_8000, -1, lat, bcnt);
    chk("t1_prod", prod_s16, 32'hFFF8_8000);
    chk("t1_ovf", 32'(ovf_s16), 32'd0);
    chk("t1_lat", 32'(lat), 32'd19);
    chk("t1_busy_cycles", 32'(bcnt), 32'd19);

    run_op(32'h7FFF_0000, 32'h0002_0000, -1, lat, bcnt);
    chk("t2_sat_prod", prod_s16, 32'h7FFF_FFFF);
    chk("t2_sat_ovf", 32'(ovf_s16), 32'd1);
    chk("t2_wrap_prod", prod_w16, 32'hFFFE_0000);
    chk("t2_wrap_ovf", 32'(ovf_w16), 32'd1);

    run_op(32'h8000_0000, 32'h0001_0000, -1, lat, bcnt);
    chk("t3_prod", prod_s16, 32'h8000_0000);
    chk("t3_ovf", 32'(ovf_s16), 32'd0);
    chk("t3_lat", 32'(lat), 32'd18);

    run_op(32'h0000_0001, 32'hFFFF_8000, -1, lat, bcnt);
    chk("t4_trunc_prod", prod_s16, 32'h0);

    run_op(32'd5, 32'd0, -1, lat, bcnt);
    chk("t5_prod", prod_s0, 32'h0);
    chk("t5_lat", 32'(lat), 32'd1);
    run_op(32'hFFFF_FFF9, 32'd6, -1, lat, bcnt);
    chk("t6_prod", prod_s0, 32'hFFFF_FFD6);
    chk("t6_lat", 32'(lat), 32'd4);

    run_op(32'h0003_0000, 32'hFFFD_8000, 5, lat, bcnt);
    chk("poke_prod", prod_s16, 32'hFFF8_8000);
    chk("poke_lat", 32'(lat), 32'd19);

    // Abort mid-operation with an asynchronous reset away from any clock edge.
    @(negedge clock);
    start = 1'b1; a_in = 32'h0001_2345; b_in = 32'h7FFF_FFFF;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_product", prod_s0, 32'h0);
    chk("arst_done", 32'(done_s0), 32'd0);
    chk("arst_busy", 32'(busy_s0), 32'd0);
    @(negedge clock);
    #1 reset = 1'b0;

    run_op(32'hFFFF_FFF9, 32'd6, -1, lat, bcnt);
    chk("post_rst_prod", prod_s0, 32'hFFFF_FFD6);

    for (int n = 0; n < 150; n++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if ($urandom_range(0, 15) == 0) rb = 32'h8000_0000;
      if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
      repeat ($urandom_range(0, 2)) @(negedge clock);
      run_op(ra, rb, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : -1, lat, bcnt);
      chk("rand_lat", 32'(lat), 32'(lat_k(rb) + 1));
    end

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
